// File: rtl/mod3_bit_serializer.sv
// rtl/mod3_bit_serializer.sv - MSB-first word serializer feeding the serial mod-3 detector.
// Optional reference remainder checker enabled by defining MOD3_REF_EN.
module mod3_bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             frame_clr,
  output logic             done,
  input  logic             det_out,
  output logic             exp_mult3,
  output logic             mismatch
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             accept;

  assign accept = in_valid && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CLR;
      CLR:     state_next = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    frame_clr = (state == CLR);
    ser_valid = (state == SHIFT);
    done      = (state == DONE);
    ser_bit   = (state == SHIFT) && shreg[WIDTH-1];
  end

  // The counter is loaded with WIDTH and SHIFT exits at 1, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= in_data;
      cnt   <= CW'(WIDTH);
    end else if (state == SHIFT) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      cnt   <= cnt - CW'(1);
    end
  end

`ifdef MOD3_REF_EN
  logic [1:0] rem;
  logic       exp_now;

  assign exp_now   = (state == DONE) && (rem == 2'd0);
  assign exp_mult3 = exp_now;

  // Remainder of the bits sent so far, tracked exactly as the detector would.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= 2'd0;
    end else if (state == CLR) begin
      rem <= 2'd0;
    end else if (state == SHIFT) begin
      case (rem)
        2'd0:    rem <= ser_bit ? 2'd1 : 2'd0;
        2'd1:    rem <= ser_bit ? 2'd0 : 2'd2;
        2'd2:    rem <= ser_bit ? 2'd2 : 2'd1;
        default: rem <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch <= 1'b0;
    end else if ((state == DONE) && (det_out != exp_now)) begin
      mismatch <= 1'b1;
    end
  end
`else
  logic unused_det;
  assign unused_det = det_out;
  assign exp_mult3  = 1'b0;
  assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_mod3_bit_serializer.sv
// tb/tb_mod3_bit_serializer.sv - directed table-driven bench for mod3_bit_serializer.
module tb_mod3_bit_serializer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ser_bit;
  logic       ser_valid;
  logic       frame_clr;
  logic       done;
  logic       det_out;
  logic       exp_mult3;
  logic       mismatch;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef MOD3_REF_EN
  localparam bit REF = 1'b1;
`else
  localparam bit REF = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       m3;
    logic       poke;
  } vec_t;

  vec_t vecs[6];

  mod3_bit_serializer #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .ser_bit(ser_bit),
    .ser_valid(ser_valid),
    .frame_clr(frame_clr),
    .done(done),
    .det_out(det_out),
    .exp_mult3(exp_mult3),
    .mismatch(mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one frame from IDLE and checks every cycle of it.
  task automatic run_frame(input logic [7:0] d, input logic m3, input logic det, input logic poke);
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    det_out  = det;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'hA5;
    chk("clr_pulse", frame_clr, 1);
    chk("clr_valid", ser_valid, 0);
    chk("clr_ready", in_ready, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("shift_valid", ser_valid, 1);
      chk("shift_bit", ser_bit, d[7-i]);
      chk("shift_ready", in_ready, 0);
      in_valid = poke && (i == 3);
    end
    in_valid = 1'b0;
    chk("pre_done_zero", done, 0);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_valid", ser_valid, 0);
    chk("done_exp", exp_mult3, REF & m3);
    @(negedge clk);
    chk("post_done", done, 0);
    chk("post_ready", in_ready, 1);
    chk("post_exp", exp_mult3, 0);
    chk("post_noclr", frame_clr, 0);
  endtask

  initial begin
    logic [7:0] cap;
    int t1;
    int t2;
    int budget;

    vecs[0] = '{8'h09, 1'b1, 1'b0};
    vecs[1] = '{8'h0A, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h55, 1'b0, 1'b1};
    vecs[5] = '{8'h96, 1'b1, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; det_out = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_bit", ser_bit, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_clr", frame_clr, 0);
    chk("rst_done", done, 0);
    chk("rst_exp", exp_mult3, 0);
    chk("rst_mismatch", mismatch, 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++)
      run_frame(vecs[v].data, vecs[v].m3, REF & vecs[v].m3, vecs[v].poke);
    chk("mismatch_clean", mismatch, 0);

    // Continuous in_valid: accept spacing and hold-until-ready.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h03; det_out = REF;
    t1 = cyc;
    @(negedge clk);
    in_data = 8'h04;
    cap = 8'h00;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (ser_valid) cap = {cap[6:0], ser_bit};
    end
    budget = 0;
    while (!in_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    t2 = cyc;
    chk("b2b_first_word", cap, 8'h03);
    chk("b2b_spacing", t2 - t1, 11);
    det_out = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_clr", frame_clr, 1);
    cap = 8'h00;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (ser_valid) cap = {cap[6:0], ser_bit};
    end
    chk("b2b_second_word", cap, 8'h04);
    chk("b2b_second_done", done, 1);
    chk("b2b_exp", exp_mult3, 0);
    @(negedge clk);
    chk("b2b_mismatch", mismatch, 0);

    // Reset during SHIFT after three bits of 0xF0.
    in_valid = 1'b1; in_data = 8'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_bit", ser_bit, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", ser_valid, 0);
    chk("rst_mid_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_mid_nodone", done | ser_valid, 0);
    end
    run_frame(8'h55, 1'b0, 1'b0, 1'b0);

    // Wrong detector answer latches mismatch when the checker is built in.
    run_frame(8'h09, 1'b1, 1'b0, 1'b0);
    chk("mismatch_set", mismatch, REF);
    run_frame(8'h0A, 1'b0, 1'b0, 1'b0);
    chk("mismatch_held", mismatch, REF);
    reset = 1'b1;
    @(negedge clk);
    chk("mismatch_rst", mismatch, 0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
